// File: rtl/door_ctrl_timed.sv
// Automatic-door controller: synchronised and debounced sensors, hold-open and motion timers,
// obstruction reversal, limit-conflict and timeout faults, and an emergency-stop state.
module door_ctrl_timed #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned HOLD_CYCLES  = 1000,
    parameter int unsigned MOVE_TIMEOUT = 5000,
    parameter int unsigned DEB_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       sensor,
    input  logic       estop,
    input  logic       lim_open,
    input  logic       lim_closed,
    input  logic       fault_clr,
    output logic       motor_open,
    output logic       motor_close,
    output logic [2:0] state,
    output logic       fault,
    output logic [1:0] fault_code
);
    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TIMEOUT - 1);
    localparam logic [DW-1:0]    DEB_LAST  = DW'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {
        StClosed  = 3'd0,
        StOpening = 3'd1,
        StOpen    = 3'd2,
        StClosing = 3'd3,
        StStopped = 3'd4,
        StFault   = 3'd5
    } state_e;

    // Bit order: {estop, lim_closed, lim_open, sensor}
    logic [3:0]          sync1_q, sync2_q;
    // Bit order: {lim_closed, lim_open, sensor}
    logic [2:0]          deb_q;
    logic [2:0][DW-1:0]  deb_cnt_q;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic [1:0]          code_q, code_d;

    logic sen_db, lo_db, lc_db, est_s;
    assign sen_db = deb_q[0];
    assign lo_db  = deb_q[1];
    assign lc_db  = deb_q[2];
    assign est_s  = sync2_q[3];

    // Synchronisers run regardless of ena so no stale pin value is held across a pause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= 3'b100;
            deb_cnt_q <= '0;
        end else begin
            sync1_q <= {estop, lim_closed, lim_open, sensor};
            sync2_q <= sync1_q;
            if (ena) begin
                for (int i = 0; i < 3; i++) begin
                    if (sync2_q[i] == deb_q[i]) begin
                        deb_cnt_q[i] <= '0;
                    end else if (deb_cnt_q[i] == DEB_LAST) begin
                        deb_cnt_q[i] <= '0;
                        deb_q[i]     <= sync2_q[i];
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        code_d  = code_q;
        if (est_s && state_q != StFault) begin
            state_d = StStopped;
        end else if (lo_db && lc_db && state_q != StFault && state_q != StStopped) begin
            state_d = StFault;
            code_d  = 2'd2;
        end else begin
            unique case (state_q)
                StClosed: begin
                    if (sen_db)      state_d = StOpening;
                    else if (!lc_db) state_d = StClosing;
                end
                StOpening: begin
                    if (!lo_db && timer_q == MOVE_LAST) begin
                        state_d = StFault;
                        code_d  = 2'd1;
                    end else if (lo_db) begin
                        state_d = StOpen;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                StOpen: begin
                    if (sen_db)              timer_d = HOLD_LOAD;
                    else if (timer_q == '0)  state_d = StClosing;
                    else                     timer_d = timer_q - CNT_W'(1);
                end
                StClosing: begin
                    if (!lc_db && timer_q == MOVE_LAST) begin
                        state_d = StFault;
                        code_d  = 2'd1;
                    end else if (sen_db) begin
                        state_d = StOpening;
                    end else if (lc_db) begin
                        state_d = StClosed;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                StStopped: begin
                    state_d = lc_db ? StClosed : StOpening;
                end
                StFault: begin
                    if (fault_clr) begin
                        state_d = lc_db ? StClosed : StOpening;
                        code_d  = 2'd0;
                    end
                end
                default: begin
                    state_d = StFault;
                    code_d  = 2'd2;
                end
            endcase
        end
        // Every entry into a motion state, reversal included, restarts the motion timer.
        if (state_d != state_q && (state_d == StOpening || state_d == StClosing)) begin
            timer_d = '0;
        end else if (state_d == StOpen && state_q != StOpen) begin
            timer_d = HOLD_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StClosed;
            timer_q     <= '0;
            code_q      <= '0;
            motor_open  <= 1'b0;
            motor_close <= 1'b0;
            fault       <= 1'b0;
        end else if (ena) begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            code_q      <= code_d;
            motor_open  <= (state_d == StOpening);
            motor_close <= (state_d == StClosing);
            fault       <= (state_d == StFault);
        end
    end

    assign state      = state_q;
    assign fault_code = code_q;

endmodule

// File: tb/tb_door_ctrl_timed.sv
// Bench for door_ctrl_timed: directed table, hand-written corner sequences and a randomized
// run, all checked against a behavioural door model.
module tb_door_ctrl_timed;
    localparam int unsigned CW   = 16;
    localparam int unsigned HOLD = 8;
    localparam int unsigned MT   = 20;
    localparam int unsigned DEB  = 2;

    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
    logic sensor = 1'b0, estop = 1'b0, lim_open = 1'b0, lim_closed = 1'b0, fault_clr = 1'b0;
    logic motor_open, motor_close, fault;
    logic [2:0] state;
    logic [1:0] fault_code;

    door_ctrl_timed #(
        .CNT_W(CW), .HOLD_CYCLES(HOLD), .MOVE_TIMEOUT(MT), .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sensor(sensor), .estop(estop),
        .lim_open(lim_open), .lim_closed(lim_closed), .fault_clr(fault_clr),
        .motor_open(motor_open), .motor_close(motor_close), .state(state),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Door model: pin pipelines, run-length debounce, elapsed-time counters.
    logic [3:0] m_s1, m_s2;     // {estop, lim_closed, lim_open, sensor}
    logic [2:0] m_deb;          // {lim_closed, lim_open, sensor}
    int m_run[3];
    int m_st, m_code, m_moved, m_quiet;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_deb = 3'b100;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
        m_st = 0; m_code = 0; m_moved = 0; m_quiet = 0;
    endtask

    task automatic model_step();
        logic sen, lo, lc, est;
        int ns, nc;
        sen = m_deb[0]; lo = m_deb[1]; lc = m_deb[2]; est = m_s2[3];
        if (ena) begin
            ns = m_st; nc = m_code;
            if (est && m_st != 5) ns = 4;
            else if (lo && lc && m_st != 5 && m_st != 4) begin ns = 5; nc = 2; end
            else if (((m_st == 1 && !lo) || (m_st == 3 && !lc)) && m_moved + 1 == MT) begin
                ns = 5; nc = 1;
            end else begin
                case (m_st)
                    0: if (sen) ns = 1; else if (!lc) ns = 3;
                    1: if (lo) ns = 2;
                    2: if (!sen && m_quiet + 1 >= HOLD) ns = 3;
                    3: if (sen) ns = 1; else if (lc) ns = 0;
                    4: ns = lc ? 0 : 1;
                    5: if (fault_clr) begin ns = lc ? 0 : 1; nc = 0; end
                    default: begin ns = 5; nc = 2; end
                endcase
            end
            if (ns == 1 || ns == 3) m_moved = (ns != m_st) ? 0 : m_moved + 1;
            if (ns == 2) m_quiet = (ns != m_st || sen) ? 0 : m_quiet + 1;
            m_st = ns; m_code = nc;
            for (int i = 0; i < 3; i++) begin
                if (m_s2[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin m_deb[i] = m_s2[i]; m_run[i] = 0; end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = {estop, lim_closed, lim_open, sensor};
    endtask

    task automatic check_model(input string tag);
        logic [7:0] got, exp;
        got = {state, motor_open, motor_close, fault, fault_code};
        exp = {3'(m_st), m_st == 1, m_st == 3, m_st == 5, 2'(m_code)};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got st/mo/mc/flt/code=%b required %b", tag, $time, got, exp);
        end
        n_vec++;
        if (motor_open && motor_close) begin
            n_bad++;
            $display("FAIL %s both_motors t=%0t: got 11 required not both 1", tag, $time);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0; ena = 1'b0; sensor = 1'b0; estop = 1'b0;
        lim_open = 1'b0; lim_closed = 1'b1; fault_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick("settle");
    endtask

    typedef struct {
        logic sen, est, lo, lc, fclr, en;
        int   cyc;
        int   st;
        int   code;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic sen, est, lo, lc, fclr, en, input int cyc, st, code);
        vec_t v;
        v.sen = sen; v.est = est; v.lo = lo; v.lc = lc; v.fclr = fclr; v.en = en;
        v.cyc = cyc; v.st = st; v.code = code;
        tbl.push_back(v);
    endtask

    initial begin
        //  sen est lo lc clr en  cyc st code
        add(0, 0, 0, 1, 0, 1,   5, 0, 0);   // idle closed
        add(1, 0, 0, 1, 0, 1,   1, 0, 0);   // one-cycle glitch
        add(0, 0, 0, 1, 0, 1,   6, 0, 0);
        add(1, 0, 0, 1, 0, 1,   4, 0, 0);   // real presence
        add(1, 0, 0, 1, 0, 1,   1, 1, 0);   // opening after 5 edges
        add(1, 0, 0, 0, 0, 1,   5, 1, 0);
        add(0, 0, 1, 0, 0, 1,   4, 1, 0);
        add(0, 0, 1, 0, 0, 1,   1, 2, 0);   // open
        add(0, 0, 1, 0, 0, 1,   7, 2, 0);
        add(0, 0, 1, 0, 0, 1,   1, 3, 0);   // hold expired
        add(0, 0, 0, 0, 0, 1,   3, 3, 0);
        add(1, 0, 0, 0, 0, 1,   4, 3, 0);
        add(1, 0, 0, 0, 0, 1,   1, 1, 0);   // reversal
        add(0, 0, 0, 0, 0, 1,  19, 1, 0);
        add(0, 0, 0, 0, 0, 1,   1, 5, 1);   // motion timeout
        add(0, 0, 0, 0, 0, 1,   5, 5, 1);
        add(0, 0, 0, 1, 0, 1,   5, 5, 1);
        add(0, 0, 0, 1, 1, 1,   1, 0, 0);   // acknowledge
        add(1, 0, 0, 1, 0, 1,   5, 1, 0);
        add(1, 0, 1, 0, 0, 1,   5, 2, 0);
        add(1, 0, 1, 1, 0, 1,   4, 2, 0);
        add(1, 0, 1, 1, 0, 1,   1, 5, 2);   // limit conflict
        add(0, 0, 0, 1, 0, 1,   5, 5, 2);
        add(0, 0, 0, 1, 1, 1,   1, 0, 0);
        add(0, 0, 0, 0, 0, 1,   5, 3, 0);   // drift closing
        add(0, 1, 0, 0, 0, 1,   2, 3, 0);
        add(0, 1, 0, 0, 0, 1,   1, 4, 0);   // estop after 3 edges
        add(0, 1, 0, 0, 0, 1,   3, 4, 0);
        add(0, 0, 0, 0, 0, 1,   2, 4, 0);
        add(0, 0, 0, 0, 0, 1,   1, 1, 0);   // release, not closed
        add(0, 0, 1, 0, 0, 1,   5, 2, 0);
        add(0, 0, 1, 0, 0, 1,   3, 2, 0);
        add(0, 0, 1, 0, 0, 0,  50, 2, 0);   // frozen
        add(0, 0, 1, 0, 0, 1,   4, 2, 0);
        add(0, 0, 1, 0, 0, 1,   1, 3, 0);

        reset_dut();
        for (int r = 0; r < tbl.size(); r++) begin
            @(negedge clk);
            sensor = tbl[r].sen; estop = tbl[r].est; lim_open = tbl[r].lo;
            lim_closed = tbl[r].lc; fault_clr = tbl[r].fclr; ena = tbl[r].en;
            for (int c = 0; c < tbl[r].cyc; c++) tick("model");
            n_vec++;
            if (state !== 3'(tbl[r].st) || fault_code !== 2'(tbl[r].code) ||
                motor_open !== (tbl[r].st == 1) || motor_close !== (tbl[r].st == 3) ||
                fault !== (tbl[r].st == 5)) begin
                n_bad++;
                $display("FAIL row%0d: got state=%0d code=%0d mo=%0d mc=%0d flt=%0d required state=%0d code=%0d",
                         r, state, fault_code, motor_open, motor_close, fault,
                         tbl[r].st, tbl[r].code);
            end
        end

        // Reverse into OPENING, then pull reset mid-cycle: motors must drop before any edge.
        @(negedge clk);
        sensor = 1'b1; lim_open = 1'b0;
        repeat (5) tick("model");
        n_vec++;
        if (motor_open !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_open: got motor_open=%0d required 1", motor_open);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (motor_open !== 1'b0 || motor_close !== 1'b0 || state !== 3'd0) begin
            n_bad++;
            $display("FAIL async_reset: got mo=%0d mc=%0d state=%0d required 0 0 0",
                     motor_open, motor_close, state);
        end

        reset_dut();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            ena = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) sensor = ~sensor;
            if ($urandom_range(0, 9) == 0) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 4)      begin lim_open = 1'b0; lim_closed = 1'b1; end
                else if (r < 8) begin lim_open = 1'b1; lim_closed = 1'b0; end
                else if (r < 9) begin lim_open = 1'b0; lim_closed = 1'b0; end
                else            begin lim_open = 1'b1; lim_closed = 1'b1; end
            end
            if ($urandom_range(0, 59) == 0) estop = ~estop;
            fault_clr = ($urandom_range(0, 5) == 0);
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
